// File: rtl/lenet_pkg.sv
// Shared definitions for the digit-classifier front end: default ROI size,
// luma coefficients and the ROI capture state encoding.
package lenet_pkg;

  localparam int ROI_W_DEF = 32;
  localparam int ROI_H_DEF = 32;

  // Luma weights; they sum to 256 so (sum >> 8) never exceeds 255.
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/rgb2grey.sv
// Two-stage pipelined RGB888 -> 8-bit luma with a valid bit and a sideband
// tag (the buffer address) carried alongside the pixel.
// Build option: ROI_GREY_CAPTURE_INVERT_EN outputs 255 - Y instead of Y.
module rgb2grey
  import lenet_pkg::*;
#(
  parameter int W_DATA = 24,
  parameter int W_TAG  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [W_DATA-1:0] i_rgb,
  input  logic [W_TAG-1:0]  i_tag,
  output logic              o_valid,
  output logic [7:0]        o_grey,
  output logic [W_TAG-1:0]  o_tag,
  output logic              o_pending
);

  logic             r_v1;
  logic [15:0]      r_pr;
  logic [15:0]      r_pg;
  logic [15:0]      r_pb;
  logic [W_TAG-1:0] r_tag1;
  logic             r_v2;
  logic [7:0]       r_grey;
  logic [W_TAG-1:0] r_tag2;
  logic [15:0]      w_sum;
  logic [7:0]       w_luma;
  logic [7:0]       w_out;

  assign w_sum  = r_pr + r_pg + r_pb;
  assign w_luma = 8'(w_sum >> 8);

`ifdef ROI_GREY_CAPTURE_INVERT_EN
  assign w_out = 8'd255 - w_luma;
`else
  assign w_out = w_luma;
`endif

  // Stage 1: per-channel products, loaded only for valid pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_pr   <= '0;
      r_pg   <= '0;
      r_pb   <= '0;
      r_tag1 <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_pr   <= 16'(COEF_R) * 16'(i_rgb[23:16]);
        r_pg   <= 16'(COEF_G) * 16'(i_rgb[15:8]);
        r_pb   <= 16'(COEF_B) * 16'(i_rgb[7:0]);
        r_tag1 <= i_tag;
      end
    end
  end

  // Stage 2: sum, shift and register the write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v2   <= 1'b0;
      r_grey <= '0;
      r_tag2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_grey <= w_out;
        r_tag2 <= r_tag1;
      end
    end
  end

  assign o_valid   = r_v2;
  assign o_grey    = r_grey;
  assign o_tag     = r_tag2;
  assign o_pending = r_v1 | r_v2;

endmodule

// File: rtl/roi_grey_capture.sv
// Captures a ROI_W x ROI_H window of the video stream at (x, y), converts it
// to luma and writes it into the classifier source buffer, then pulses
// capture_ready once per completed window.
// Build option: ROI_GREY_CAPTURE_INVERT_EN stores 255 - Y (white-on-black).
module roi_grey_capture
  import lenet_pkg::*;
#(
  parameter int W_DATA  = 24,
  parameter int W_COORD = 12,
  parameter int ROI_W   = ROI_W_DEF,
  parameter int ROI_H   = ROI_H_DEF,
  parameter int W_ADDR  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_en,
  input  logic [W_COORD-1:0] x,
  input  logic [W_COORD-1:0] y,
  input  logic               cam_vsync_i,
  input  logic               cam_href_i,
  input  logic [W_DATA-1:0]  cam_data_i,
  output logic               busy,
  output logic               capture_ready,
  output logic [W_ADDR-1:0]  ab_frame_buf,
  output logic               cenb_frame_buf,
  output logic [7:0]         db_frame_buf
);

  localparam int LOG_W = $clog2(ROI_W);
  localparam int LOG_H = W_ADDR - LOG_W;
  localparam logic [W_COORD:0]   ROI_W_EXT = (W_COORD+1)'(ROI_W);
  localparam logic [W_COORD:0]   ROI_H_EXT = (W_COORD+1)'(ROI_H);
  localparam logic [LOG_W-1:0]   LAST_COL  = LOG_W'(ROI_W - 1);
  localparam logic [LOG_H-1:0]   LAST_ROW  = LOG_H'(ROI_H - 1);
  localparam logic [W_COORD-1:0] ONE_C     = W_COORD'(1);

  logic               r_vsync_d;
  logic               r_href_d;
  logic [W_DATA-1:0]  r_data_d;
  logic [W_COORD-1:0] r_col;
  logic [W_COORD-1:0] r_row;
  logic [W_COORD-1:0] r_x;
  logic [W_COORD-1:0] r_y;
  cap_state_t         r_state;
  cap_state_t         w_state_next;

  logic               w_vs_rise;
  logic               w_href_rise;
  logic               w_href_fall;
  logic [W_COORD:0]   w_col_ext;
  logic [W_COORD:0]   w_row_ext;
  logic [W_COORD:0]   w_x_ext;
  logic [W_COORD:0]   w_y_ext;
  logic               w_in_roi;
  logic               w_live;
  logic               w_accept;
  logic               w_last;
  logic [LOG_W-1:0]   w_col_off;
  logic [LOG_H-1:0]   w_row_off;
  logic [W_ADDR-1:0]  w_addr;
  logic               w_busy;
  logic               w_ready;
  logic               w_pending;
  logic               w_grey_valid;

  assign w_vs_rise   = cam_vsync_i & ~r_vsync_d;
  assign w_href_rise = cam_href_i & ~r_href_d;
  assign w_href_fall = ~cam_href_i & r_href_d;

  // One extra bit so x+ROI_W past the coordinate range clips instead of wrapping.
  assign w_col_ext = {1'b0, r_col};
  assign w_row_ext = {1'b0, r_row};
  assign w_x_ext   = {1'b0, r_x};
  assign w_y_ext   = {1'b0, r_y};
  assign w_in_roi  = r_href_d
                   && (w_col_ext >= w_x_ext) && (w_col_ext < w_x_ext + ROI_W_EXT)
                   && (w_row_ext >= w_y_ext) && (w_row_ext < w_y_ext + ROI_H_EXT);

  // Low offset bits only depend on the low coordinate bits.
  assign w_col_off = r_col[LOG_W-1:0] - r_x[LOG_W-1:0];
  assign w_row_off = r_row[LOG_H-1:0] - r_y[LOG_H-1:0];
  assign w_addr    = {w_row_off, w_col_off};

  assign w_live   = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign w_accept = w_in_roi && w_live && !w_vs_rise;
  assign w_last   = w_accept && (w_col_off == LAST_COL) && (w_row_off == LAST_ROW);

  // Delayed copies of the sync inputs; the data path follows the delayed href
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
      r_data_d  <= '0;
    end else begin
      r_vsync_d <= cam_vsync_i;
      r_href_d  <= cam_href_i;
      r_data_d  <= cam_data_i;
    end
  end

  // Column/row counters and ROI origin shadows captured at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      if (w_vs_rise) begin
        r_x   <= x;
        r_y   <= y;
        r_row <= '0;
      end else if (w_href_fall) begin
        r_row <= r_row + ONE_C;
      end
      if (w_href_rise) begin
        r_col <= '0;
      end else if (cam_href_i) begin
        r_col <= r_col + ONE_C;
      end
    end
  end

  // Capture state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, busy and ready decode; a vsync edge while live aborts and re-arms
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vs_rise && capture_en) w_state_next = ST_ARMED;
      end
      ST_ARMED: begin
        w_busy = w_accept;
        if (w_vs_rise)     w_state_next = capture_en ? ST_ARMED : ST_IDLE;
        else if (w_last)   w_state_next = ST_DONE;
        else if (w_accept) w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_busy = 1'b1;
        if (w_vs_rise)   w_state_next = capture_en ? ST_ARMED : ST_IDLE;
        else if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (w_pending) begin
          w_busy = 1'b1;
        end else begin
          w_ready      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  rgb2grey #(
    .W_DATA (W_DATA),
    .W_TAG  (W_ADDR)
  ) u_rgb2grey (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (w_accept),
    .i_rgb     (r_data_d),
    .i_tag     (w_addr),
    .o_valid   (w_grey_valid),
    .o_grey    (db_frame_buf),
    .o_tag     (ab_frame_buf),
    .o_pending (w_pending)
  );

  assign cenb_frame_buf = ~w_grey_valid;
  assign busy           = w_busy;
  assign capture_ready  = w_ready;

endmodule

// File: tb/tb_roi_grey_capture.sv
// Self-checking bench for roi_grey_capture: constant-pixel table, ramp and
// random frames checked against a buffer-content model, plus abort, reset,
// clipping and capture_en corner sequences.
module tb_roi_grey_capture;

`ifdef ROI_GREY_CAPTURE_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_en;
  logic [11:0] x;
  logic [11:0] y;
  logic        cam_vsync_i;
  logic        cam_href_i;
  logic [23:0] cam_data_i;
  logic        busy;
  logic        capture_ready;
  logic [9:0]  ab_frame_buf;
  logic        cenb_frame_buf;
  logic [7:0]  db_frame_buf;

  roi_grey_capture dut (
    .clk            (clk),
    .rst            (rst),
    .capture_en     (capture_en),
    .x              (x),
    .y              (y),
    .cam_vsync_i    (cam_vsync_i),
    .cam_href_i     (cam_href_i),
    .cam_data_i     (cam_data_i),
    .busy           (busy),
    .capture_ready  (capture_ready),
    .ab_frame_buf   (ab_frame_buf),
    .cenb_frame_buf (cenb_frame_buf),
    .db_frame_buf   (db_frame_buf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // monitor state (written only by the monitor)
  int         cyc = 0;
  int         wr_count = 0;
  int         ready_count = 0;
  int         last_wr_cyc = 0;
  int         ready_cyc = 0;
  logic       busy_at_last = 1'b0;
  logic [7:0] mem [0:1023];
  int         wframe [0:1023];

  // stimulus-side state
  int          fid = 0;
  int          wr_base = 0;
  int          ready_base = 0;
  int          cur_x = 0;
  int          cur_y = 0;
  logic [23:0] fpix [0:4095];

  typedef struct {
    logic [23:0] px;
    logic [7:0]  y_plain;
    logic [7:0]  y_inv;
  } vec_t;
  vec_t vt [4];

  // Buffer-port monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cenb_frame_buf === 1'b0) begin
      wr_count = wr_count + 1;
      mem[ab_frame_buf] = db_frame_buf;
      wframe[ab_frame_buf] = fid;
      last_wr_cyc = cyc;
      busy_at_last = busy;
    end
    if (capture_ready === 1'b1) begin
      ready_count = ready_count + 1;
      ready_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] luma(input logic [23:0] p);
    int s;
    s = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    if (INV) s = 255 - s;
    return 8'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 normal, 1 stop frame after nlim writes, 2 pulse rst after nlim writes
  // pmode: 0 constant cpx, 1 ramp, 2 random
  task automatic drive_frame(input int fw, input int fh, input int cx, input int cy,
                             input bit en_vs, input bit en_mid, input int mode,
                             input int nlim, input int pmode, input logic [23:0] cpx);
    bit stop;
    bit rst_done;
    int wr_at_rst;
    int rdy_at_rst;
    stop = 0;
    rst_done = 0;
    wr_at_rst = 0;
    rdy_at_rst = 0;
    for (int r = 0; r < fh; r++) begin
      for (int c = 0; c < fw; c++) begin
        if (pmode == 0)      fpix[r*64+c] = cpx;
        else if (pmode == 1) fpix[r*64+c] = {8'(r), 8'(c), 8'(r + 3*c)};
        else                 fpix[r*64+c] = 24'($urandom);
      end
    end
    fid++;
    wr_base = wr_count;
    ready_base = ready_count;
    cur_x = cx;
    cur_y = cy;
    x = 12'(cx);
    y = 12'(cy);
    capture_en = en_vs;
    cam_vsync_i = 1'b1;
    repeat (3) tick();
    capture_en = en_mid;
    cam_vsync_i = 1'b0;
    repeat (2) tick();
    for (int r = 0; r < fh && !stop; r++) begin
      for (int c = 0; c < fw && !stop; c++) begin
        if (mode == 1 && (wr_count - wr_base) >= nlim) begin
          stop = 1;
        end else begin
          cam_href_i = 1'b1;
          cam_data_i = fpix[r*64+c];
          if (mode == 2 && !rst_done && (wr_count - wr_base) >= nlim) rst = 1'b1;
          tick();
          if (rst) begin
            chk("rst_cenb", 32'(cenb_frame_buf), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            rst = 1'b0;
            rst_done = 1;
            wr_at_rst = wr_count;
            rdy_at_rst = ready_count;
          end
        end
      end
      cam_href_i = 1'b0;
      cam_data_i = '0;
      repeat (4) tick();
    end
    repeat (6) tick();
    if (mode == 2) begin
      chk("rst_fired", 32'(rst_done), 32'd1);
      chk("rst_no_writes_after", 32'(wr_count - wr_at_rst), 32'd0);
      chk("rst_no_ready", 32'(ready_count - rdy_at_rst), 32'd0);
    end
    $display("frame %0d: %0dx%0d roi=(%0d,%0d) en=%0d mode=%0d writes=%0d ready=%0d",
             fid, fw, fh, cx, cy, en_vs, mode, wr_count - wr_base, ready_count - ready_base);
  endtask

  // Full-capture checks against the buffer model built from fpix
  task automatic check_full(input string tag);
    int bad;
    logic [23:0] p;
    bad = 0;
    for (int a = 0; a < 1024; a++) begin
      p = fpix[(cur_y + a / 32) * 64 + cur_x + a % 32];
      if (wframe[a] != fid || mem[a] !== luma(p)) bad++;
    end
    chk({tag, "_writes"}, 32'(wr_count - wr_base), 32'd1024);
    chk({tag, "_ready_count"}, 32'(ready_count - ready_base), 32'd1);
    chk({tag, "_ready_gap"}, 32'(ready_cyc - last_wr_cyc), 32'd1);
    chk({tag, "_busy_last_wr"}, 32'(busy_at_last), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_bad_addrs"}, 32'(bad), 32'd0);
    chk({tag, "_addr0"}, 32'(mem[0]), 32'(luma(fpix[cur_y*64 + cur_x])));
    chk({tag, "_addr1023"}, 32'(mem[1023]), 32'(luma(fpix[(cur_y+31)*64 + cur_x + 31])));
  endtask

  initial begin
    vt[0] = '{24'hFF0000, 8'd76,  8'd179};
    vt[1] = '{24'h00FF00, 8'd149, 8'd106};
    vt[2] = '{24'hFFFFFF, 8'd255, 8'd0};
    vt[3] = '{24'h808080, 8'd128, 8'd127};

    rst = 1'b1;
    capture_en = 1'b0;
    x = '0;
    y = '0;
    cam_vsync_i = 1'b0;
    cam_href_i = 1'b0;
    cam_data_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(capture_ready), 32'd0);
    chk("reset_cenb", 32'(cenb_frame_buf), 32'd1);
    chk("reset_ab", 32'(ab_frame_buf), 32'd0);
    chk("reset_db", 32'(db_frame_buf), 32'd0);

    // constant-colour table
    for (int i = 0; i < 4; i++) begin
      drive_frame(40, 34, 4, 1, 1'b1, 1'b1, 0, 0, 0, vt[i].px);
      chk($sformatf("const%0d_addr0", i), 32'(mem[0]), 32'(INV ? vt[i].y_inv : vt[i].y_plain));
      chk($sformatf("const%0d_writes", i), 32'(wr_count - wr_base), 32'd1024);
      chk($sformatf("const%0d_ready", i), 32'(ready_count - ready_base), 32'd1);
    end

    // ramp frame, 64x48 at (16,8)
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 0, 0, 1, '0);
    check_full("ramp");

    // random frames at random origins
    for (int i = 0; i < 3; i++) begin
      drive_frame(64, 48, int'($urandom_range(0, 32)), int'($urandom_range(0, 16)),
                  1'b1, 1'b1, 0, 0, 2, '0);
      check_full($sformatf("rand%0d", i));
    end

    // ROI clipped on the right: no completion, stays live until next vsync
    drive_frame(64, 48, 48, 8, 1'b1, 1'b1, 0, 0, 2, '0);
    chk("clip_ready", 32'(ready_count - ready_base), 32'd0);
    chk("clip_busy_held", 32'(busy), 32'd1);
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 0, 0, 2, '0);
    check_full("after_clip");

    // vsync re-asserted after 500 writes
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 1, 500, 2, '0);
    chk("abort_reached_500", 32'((wr_count - wr_base) >= 500), 32'd1);
    chk("abort_ready", 32'(ready_count - ready_base), 32'd0);
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 0, 0, 2, '0);
    check_full("after_abort");

    // reset pulsed mid-capture
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 2, 300, 2, '0);
    chk("rst_frame_ready", 32'(ready_count - ready_base), 32'd0);
    drive_frame(64, 48, 16, 8, 1'b1, 1'b1, 0, 0, 2, '0);
    check_full("after_rst");

    // capture_en low at vsync, raised mid-frame
    drive_frame(64, 48, 16, 8, 1'b0, 1'b1, 0, 0, 2, '0);
    chk("en0_writes", 32'(wr_count - wr_base), 32'd0);
    chk("en0_ready", 32'(ready_count - ready_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
